// File: rtl/host_cmd_if.sv
// Byte-stream and CPU_top debug-port signals of the host command master.
// master: the command initiator; slave: the UART/CPU side it talks to.
interface host_cmd_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  cmd;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    input  rx_data, rx_valid, tx_ready, data_out,
    output rx_ready, tx_data, tx_valid, cmd, addr_in, data_in
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, data_out,
    input  rx_ready, tx_data, tx_valid, cmd, addr_in, data_in
  );
endinterface

// File: rtl/host_cmd_master.sv
// Host command initiator: parses opcode/address/data byte frames from the
// UART receiver, issues one-cycle cmd transactions to CPU_top, and returns
// ACK / ERR / read-data bytes on the transmit stream.
module host_cmd_master #(
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned TIMEOUT  = 100000,
  parameter logic [7:0]  ACK_BYTE = 8'h06,
  parameter logic [7:0]  ERR_BYTE = 8'h15
) (
  input logic        clk,
  input logic        reset,
  host_cmd_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = $clog2(READ_LAT + 2);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, ISSUE, WAIT_RD, RESP} state_t;

  state_t        state;
  logic [1:0]    op;         // cmd code latched from the opcode byte
  logic [1:0]    byte_cnt;   // byte lane within the current address/data word
  logic [TW-1:0] to_cnt;     // idle cycles since the last accepted frame byte
  logic [WW-1:0] wait_cnt;   // cycles elapsed since the read issue cycle
  logic [2:0]    resp_left;  // response bytes still to be handed to TX
  logic [31:0]   rsp;        // read data, shifted down one byte per handshake
  logic          rx_hs;
  logic          tx_hs;

  assign rx_hs = bus.rx_valid && bus.rx_ready;
  assign tx_hs = bus.tx_valid && bus.tx_ready;

  // Frame parser, command issue, read wait and response FSM; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      op           <= 2'b00;
      byte_cnt     <= 2'd0;
      to_cnt       <= '0;
      wait_cnt     <= '0;
      resp_left    <= 3'd0;
      rsp          <= 32'h0;
      bus.rx_ready <= 1'b1;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.cmd      <= 2'b00;
      bus.addr_in  <= 32'h0;
      bus.data_in  <= 32'h0;
    end else begin
      bus.cmd <= 2'b00;
      unique case (state)
        IDLE: begin
          if (rx_hs) begin
            byte_cnt <= 2'd0;
            to_cnt   <= '0;
            case (bus.rx_data)
              8'h01: begin op <= 2'b01; state <= ADDR; end
              8'h02: begin op <= 2'b10; state <= ADDR; end
              8'h03: begin op <= 2'b11; state <= ADDR; end
              default: begin
                state        <= RESP;
                bus.rx_ready <= 1'b0;
                bus.tx_valid <= 1'b1;
                bus.tx_data  <= ERR_BYTE;
                resp_left    <= 3'd1;
              end
            endcase
          end
        end
        ADDR, DATA: begin
          // An accepted byte always wins over a timeout in the same cycle.
          if (rx_hs) begin
            to_cnt   <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == ADDR) bus.addr_in[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
            else               bus.data_in[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
            if (byte_cnt == 2'd3) begin
              if (state == ADDR && op != 2'b11) begin
                state <= DATA;
              end else begin
                state        <= ISSUE;
                bus.cmd      <= op;
                bus.rx_ready <= 1'b0;
              end
            end
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            state  <= IDLE;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        ISSUE: begin
          if (op == 2'b11) begin
            state    <= WAIT_RD;
            wait_cnt <= WW'(1);
          end else begin
            state        <= RESP;
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= ACK_BYTE;
            resp_left    <= 3'd1;
          end
        end
        WAIT_RD: begin
          if (wait_cnt == WW'(READ_LAT)) begin
            rsp          <= bus.data_out;
            bus.tx_data  <= bus.data_out[7:0];
            bus.tx_valid <= 1'b1;
            resp_left    <= 3'd4;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        RESP: begin
          if (tx_hs) begin
            resp_left <= resp_left - 3'd1;
            if (resp_left == 3'd1) begin
              bus.tx_valid <= 1'b0;
              bus.rx_ready <= 1'b1;
              state        <= IDLE;
            end else begin
              bus.tx_data <= rsp[15:8];
              rsp         <= {8'h00, rsp[31:8]};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
